// File: rtl/turfio_trig_pkg.sv
// turfio_trig_pkg: shared sizes and output field layout for the TURFIO trigger merge
package turfio_trig_pkg;
  localparam int NLANE_DEF = 8;
  localparam int WORD_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int LANE_W = $clog2(NLANE_DEF);
  localparam int TDATA_WORD_LSB = 0;
  localparam int TDATA_LANE_LSB = 16;
  localparam int TDATA_WIDTH = 24;
endpackage

// File: rtl/trig_rr_arbiter.sv
// trig_rr_arbiter: picks the first requesting lane at or after the round-robin pointer
module trig_rr_arbiter import turfio_trig_pkg::*; #(
  parameter int N = NLANE_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] gnt_o,
  output logic         any_o
);
  always_comb begin
    gnt_o = ptr_i;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[ptr_i + W'(i)]) gnt_o = ptr_i + W'(i);
  end
  assign any_o = |req_i;
endmodule

// File: rtl/turfio_trig_merge.sv
// turfio_trig_merge: buffers per-lane trigger words and serialises them round-robin onto one valid/ready stream
module turfio_trig_merge import turfio_trig_pkg::*; #(
  parameter int NLANE = NLANE_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [NLANE*WORD_WIDTH-1:0] trig_i,
  input  logic [NLANE-1:0]            trig_valid_i,
  input  logic [NLANE-1:0]            lane_mask_i,
  input  logic                        ovf_clr_i,
  output logic [TDATA_WIDTH-1:0]      m_tdata_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i,
  output logic [NLANE-1:0]            pending_o,
  output logic [NLANE*CNT_WIDTH-1:0]  ovf_count_o
);
  localparam int LW = $clog2(NLANE);
  logic [WORD_WIDTH-1:0] pend_data_q [NLANE];
  logic [WORD_WIDTH-1:0] pend_data_d [NLANE];
  logic [CNT_WIDTH-1:0] ovf_q [NLANE];
  logic [CNT_WIDTH-1:0] ovf_d [NLANE];
  logic [NLANE-1:0] pending_q, pending_d, cap, keep;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic tvalid_q, tvalid_d, load_en, any, grant_en;
  logic [LW-1:0] rr_q, rr_d, gnt;
  trig_rr_arbiter #(.N(NLANE)) u_arb (
    .req_i (pending_q),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .any_o (any)
  );
  always_comb begin
    load_en = !tvalid_q || m_tready_i;
    grant_en = load_en && any;
    cap = trig_valid_i & lane_mask_i;
    keep = '0;
    pending_d = '0;
    for (int j = 0; j < NLANE; j++) begin
      keep[j] = pending_q[j] && !(grant_en && gnt == LW'(j));
      pending_d[j] = keep[j] || cap[j];
      pend_data_d[j] = cap[j] && !keep[j] ? trig_i[WORD_WIDTH*j +: WORD_WIDTH] : pend_data_q[j];
      ovf_d[j] = ovf_clr_i ? CNT_WIDTH'(cap[j] && keep[j])
                           : ovf_q[j] + CNT_WIDTH'(cap[j] && keep[j] && ovf_q[j] != '1);
    end
    tdata_d = tdata_q;
    if (grant_en) begin
      tdata_d = '0;
      tdata_d[TDATA_LANE_LSB +: LW] = gnt;
      tdata_d[TDATA_WORD_LSB +: WORD_WIDTH] = pend_data_q[gnt];
    end
    tvalid_d = load_en ? any : tvalid_q;
    rr_d = grant_en ? gnt + LW'(1) : rr_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
      pend_data_q <= '{default: '0};
      ovf_q <= '{default: '0};
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      rr_q <= '0;
    end else begin
      pending_q <= pending_d;
      pend_data_q <= pend_data_d;
      ovf_q <= ovf_d;
      tdata_q <= tdata_d;
      tvalid_q <= tvalid_d;
      rr_q <= rr_d;
    end
  end
  assign m_tdata_o = tdata_q;
  assign m_tvalid_o = tvalid_q;
  assign pending_o = pending_q;
  for (genvar k = 0; k < NLANE; k++) assign ovf_count_o[CNT_WIDTH*k +: CNT_WIDTH] = ovf_q[k];
endmodule

// File: tb/tb_turfio_trig_merge.sv
// tb_turfio_trig_merge: table, directed and randomized checks of turfio_trig_merge against a reference model
module tb_turfio_trig_merge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [127:0] trig = '0;
  logic [7:0] vld = '0;
  logic [7:0] mask = 8'hFF;
  logic clr = 1'b0;
  logic tready = 1'b0;
  logic [23:0] tdata;
  logic tvalid;
  logic [7:0] pend;
  logic [63:0] ovf;
  always #5 clk = ~clk;
  turfio_trig_merge dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .trig_i       (trig),
    .trig_valid_i (vld),
    .lane_mask_i  (mask),
    .ovf_clr_i    (clr),
    .m_tdata_o    (tdata),
    .m_tvalid_o   (tvalid),
    .m_tready_i   (tready),
    .pending_o    (pend),
    .ovf_count_o  (ovf)
  );
  int nvec = 0;
  int nerr = 0;
  bit mpend [8];
  logic [15:0] mdata [8];
  int mcnt [8];
  bit mv;
  logic [23:0] md;
  int rr;
  int drops;
  bit sat;
  typedef struct {
    logic [7:0] valid;
    logic [7:0] mask;
    logic [15:0] base;
    logic ready;
    logic exp_v;
    logic [23:0] exp_d;
    logic [7:0] exp_p;
  } vec_t;
  vec_t tbl [$];
  function automatic vec_t mk(logic [7:0] v, logic [7:0] m, logic [15:0] b, logic r, logic ev, logic [23:0] ed, logic [7:0] ep);
    vec_t t;
    t.valid = v; t.mask = m; t.base = b; t.ready = r; t.exp_v = ev; t.exp_d = ed; t.exp_p = ep;
    return t;
  endfunction
  task model();
    int g;
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) begin mpend[j] = 0; mdata[j] = '0; mcnt[j] = 0; end
      mv = 0; md = '0; rr = 0; drops = 0; sat = 0;
      return;
    end
    g = -1;
    if (!mv || tready) begin
      for (int k = 0; k < 8 && g < 0; k++) if (mpend[(rr + k) % 8]) g = (rr + k) % 8;
      mv = (g >= 0);
      if (g >= 0) begin
        md = {5'b0, 3'(g), mdata[g]};
        mpend[g] = 0;
        rr = (g + 1) % 8;
      end
    end
    if (clr) begin
      drops = 0; sat = 0;
      for (int j = 0; j < 8; j++) mcnt[j] = 0;
    end
    for (int j = 0; j < 8; j++)
      if (vld[j] && mask[j]) begin
        if (mpend[j]) begin
          drops++;
          if (mcnt[j] < 255) mcnt[j]++; else sat = 1;
        end else begin
          mpend[j] = 1;
          mdata[j] = trig[16*j +: 16];
        end
      end
  endtask
  function automatic logic [63:0] m_ovf();
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(mcnt[j]);
    return r;
  endfunction
  function automatic logic [7:0] m_pend();
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = mpend[j];
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    model();
    #1;
  endtask
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic set_words(logic [15:0] base);
    for (int j = 0; j < 8; j++) trig[16*j +: 16] = base + 16'(j);
  endtask
  initial begin
    logic [7:0] p;
    int l, s;
    step();
    step();
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tdata", 64'(tdata), 64'(0));
    chk("rst_pending", 64'(pend), 64'(0));
    chk("rst_ovf", ovf, 64'(0));
    rst_n = 1'b1;
    tbl.push_back(mk(8'hFF, 8'hFF, 16'hA000, 1, 0, 0, 8'hFF));
    for (int j = 0; j < 8; j++)
      tbl.push_back(mk(8'h00, 8'hFF, 16'hA000, 1, 1, {5'b0, 3'(j), 16'hA000 + 16'(j)}, 8'(8'hFF << (j + 1))));
    tbl.push_back(mk(8'h00, 8'hFF, 16'hA000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(8'h04, 8'hFF, 16'hA000, 1, 0, 0, 8'h04));
    tbl.push_back(mk(8'h00, 8'hFF, 16'hA000, 1, 1, 24'h02A002, 8'h00));
    tbl.push_back(mk(8'hFF, 8'hFF, 16'hA000, 1, 0, 0, 8'hFF));
    p = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      l = (3 + k) % 8;
      p[l] = 1'b0;
      tbl.push_back(mk(8'h00, 8'hFF, 16'hA000, 1, 1, {5'b0, 3'(l), 16'hA000 + 16'(l)}, p));
    end
    tbl.push_back(mk(8'h00, 8'hFF, 16'hA000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(8'h01, 8'hFE, 16'hA000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 16'hA000, 1, 0, 0, 8'h00));
    tbl.push_back(mk(8'h20, 8'hFF, 16'h122F, 1, 0, 0, 8'h20));
    tbl.push_back(mk(8'h00, 8'hFF, 16'h122F, 1, 1, 24'h051234, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 16'h122F, 1, 0, 0, 8'h00));
    foreach (tbl[i]) begin
      vld = tbl[i].valid;
      mask = tbl[i].mask;
      tready = tbl[i].ready;
      set_words(tbl[i].base);
      step();
      chk($sformatf("tbl%0d_tvalid", i), 64'(tvalid), 64'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk($sformatf("tbl%0d_tdata", i), 64'(tdata), 64'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_pending", i), 64'(pend), 64'(tbl[i].exp_p));
      chk($sformatf("tbl%0d_ovf", i), ovf, 64'(0));
    end
    mask = 8'hFF;
    tready = 1'b0;
    vld = 8'h01; trig[15:0] = 16'h00AA; step();
    vld = 8'h00; step();
    chk("col_stall_tvalid", 64'(tvalid), 64'(1));
    vld = 8'h04; trig[47:32] = 16'h0001; step();
    trig[47:32] = 16'h0002; step();
    chk("col_ovf2", 64'(ovf[23:16]), 64'(1));
    chk("col_pending", 64'(pend), 64'(8'h04));
    chk("col_stall_tdata", 64'(tdata), 64'(24'h0000AA));
    vld = 8'h00; tready = 1'b1; step();
    chk("col_out_tvalid", 64'(tvalid), 64'(1));
    chk("col_out_tdata", 64'(tdata), 64'(24'h020001));
    step();
    chk("col_drain_tvalid", 64'(tvalid), 64'(0));
    tready = 1'b0;
    vld = 8'h01; step();
    vld = 8'h00; step();
    vld = 8'h80; trig[127:112] = 16'h7777; step();
    for (int i = 0; i < 300; i++) step();
    chk("sat_ovf7", 64'(ovf[63:56]), 64'(255));
    clr = 1'b1; step();
    chk("clr_drop_ovf", ovf, 64'h0100_0000_0000_0000);
    clr = 1'b0; vld = 8'h00; tready = 1'b1;
    repeat (3) step();
    tready = 1'b0;
    vld = 8'hFF; set_words(16'hC000); step();
    vld = 8'h00; step();
    vld = 8'hFF; step();
    chk("mrst_pre_tvalid", 64'(tvalid), 64'(1));
    chk("mrst_pre_pending", 64'(pend), 64'(8'hFF));
    rst_n = 1'b0; vld = 8'h00; step();
    rst_n = 1'b1;
    chk("mrst_tvalid", 64'(tvalid), 64'(0));
    chk("mrst_tdata", 64'(tdata), 64'(0));
    chk("mrst_pending", 64'(pend), 64'(0));
    chk("mrst_ovf", ovf, 64'(0));
    for (int c = 0; c < 10; c++) begin
      for (int n = 0; n < 1000; n++) begin
        clr = (n == 0);
        vld = 8'($urandom & $urandom & $urandom);
        mask = ($urandom_range(7) == 0) ? 8'($urandom) : 8'hFF;
        tready = ($urandom_range(3) != 0);
        for (int j = 0; j < 8; j++) trig[16*j +: 16] = 16'($urandom);
        step();
        chk("rnd_tvalid", 64'(tvalid), 64'(mv));
        if (mv) chk("rnd_tdata", 64'(tdata), 64'(md));
        chk("rnd_pending", 64'(pend), 64'(m_pend()));
        chk("rnd_ovf", ovf, m_ovf());
      end
      clr = 1'b0;
      if (!sat) begin
        s = 0;
        for (int j = 0; j < 8; j++) s += int'(ovf[8*j +: 8]);
        chk($sformatf("rnd_drop_sum%0d", c), 64'(s), 64'(drops));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
